// File: rtl/word_serializer_msb.sv
// rtl/word_serializer_msb.sv - MSB-first parallel-to-serial stage with frame markers.
// Define PARITY_APPEND_EN to append an even-parity bit after each word.
module word_serializer_msb #(
    parameter int W          = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         bit_out,
    output logic         bit_valid,
    output logic         frame_start,
    output logic         frame_end,
    output logic         parity_flag,
    output logic         busy
);

    localparam int              CW          = $clog2(W + 1);
    localparam logic [CW-1:0]   LP_CNT_TOP  = CW'(W - 1);
    localparam logic [3:0]      LP_GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit              LP_HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_shreg;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_gap_cnt;
    logic           w_last_data;
    logic           w_frame_done;
    logic           w_accept;

    assign w_last_data = (r_state == S_SHIFT) && (r_cnt == '0);

`ifdef PARITY_APPEND_EN
    logic r_par;
    assign w_frame_done = (r_state == S_PAR);
    assign parity_flag  = (r_state == S_PAR);
    assign bit_out      = (r_state == S_SHIFT) ? r_shreg[W-1] :
                          (r_state == S_PAR)   ? r_par        : 1'b0;
`else
    assign w_frame_done = w_last_data;
    assign parity_flag  = 1'b0;
    assign bit_out      = (r_state == S_SHIFT) ? r_shreg[W-1] : 1'b0;
`endif

    // Last frame cycle doubles as an accept window only when no gap follows.
    assign load_ready  = !reset && ((r_state == S_IDLE) || (w_frame_done && !LP_HAS_GAP));
    assign w_accept    = load_valid && load_ready;
    assign bit_valid   = (r_state == S_SHIFT) || (r_state == S_PAR);
    assign frame_start = (r_state == S_SHIFT) && (r_cnt == LP_CNT_TOP);
    assign frame_end   = w_frame_done;
    assign busy        = (r_state != S_IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
`ifdef PARITY_APPEND_EN
                    w_state_next = S_PAR;
`else
                    if (w_accept)        w_state_next = S_SHIFT;
                    else if (LP_HAS_GAP) w_state_next = S_GAP;
                    else                 w_state_next = S_IDLE;
`endif
                end
            end
            S_PAR: begin
                if (w_accept)        w_state_next = S_SHIFT;
                else if (LP_HAS_GAP) w_state_next = S_GAP;
                else                 w_state_next = S_IDLE;
            end
            S_GAP: begin
                if (r_gap_cnt == LP_GAP_LAST) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
`ifdef PARITY_APPEND_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_shreg <= data_in;
                r_cnt   <= LP_CNT_TOP;
`ifdef PARITY_APPEND_EN
                r_par   <= ^data_in;
`endif
            end else if (r_state == S_SHIFT) begin
                r_shreg <= {r_shreg[W-2:0], 1'b0};
                if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            end
            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 4'd1;
            else                  r_gap_cnt <= 4'd0;
        end
    end

endmodule
